// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encodings, widths and address helper
package i2c_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;
    localparam int STATE_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WRITE     = 4'd3,
        ST_WRITE_ACK = 4'd4,
        ST_READ      = 4'd5,
        ST_READ_ACK  = 4'd6,
        ST_WAIT_STOP = 4'd7
    } i2c_state_e;

    // Upper seven bits of the address byte are the bus address, bit 0 is R/W.
    function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                        input logic [6:0] own_addr);
        return addr_byte[BYTE_W-1:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizer chains plus one history flop; idle bus level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // SDA transitions only count as START/STOP while SCL is steadily high.
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with byte receive and transmit handshakes
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR    = 7'b1010101,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCL,
    inout  wire         SDA,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        busy,
    output logic [3:0]  state_reg
);

    i2c_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_req_q, tx_req_d;
    logic                 busy_q, busy_d;
    logic                 oe_q, oe_d;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    // Open-drain output: the target only ever pulls low.
    assign SDA = oe_q ? 1'b0 : 1'bz;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
        end
    end

    // Next-state logic: STOP/START override everything; SDA drive changes only on SCL fall.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        oe_d       = oe_q;
        if (stop_det) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_match(shift_d, OWN_ADDR)) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First fall starts the ack pull-down, second fall ends it.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        bit_cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = ST_READ;
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            oe_d     = ~tx_data[7];
                        end else begin
                            state_d = ST_WRITE;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shift_d   = {shift_q[BYTE_W-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = ST_WRITE;
                    end
                end
                // Bit 7 went out on entry; each fall presents the next bit.
                ST_READ: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        oe_d      = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_READ_ACK;
                    end else begin
                        shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
                        oe_d      = ~shift_q[BYTE_W-2];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                // A NACK leaves on the rise, so any fall seen here follows an ACK.
                ST_READ_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_d = ST_WAIT_STOP;
                        busy_d  = 1'b0;
                    end else if (scl_fall) begin
                        state_d   = ST_READ;
                        shift_d   = tx_data;
                        tx_req_d  = 1'b1;
                        oe_d      = ~tx_data[7];
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign state_reg = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target driving a modelled bus master
module tb_i2c_target;

    localparam int H = 8;

    typedef struct {
        logic       rd;
        logic [6:0] addr;
        int         nbytes;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_rx;
        int         exp_tx;
        logic [7:0] exp_rx_data;
        logic [3:0] exp_state;
        logic       exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_r = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;
    logic [3:0] state_reg;

    int rx_cnt = 0, tx_cnt = 0, drv_cnt = 0;
    int n_pass = 0, n_total = 0;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    i2c_target #(.OWN_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .SCL       (scl_r),
        .SDA       (sda_w),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy),
        .state_reg (state_reg)
    );

    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req)   tx_cnt <= tx_cnt + 1;
    end

    always @(negedge clk) begin
        if (sda_w === 1'b0 && !m_low) drv_cnt <= drv_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        wait_n(2);
        m_low = ~b;
        wait_n(H - 2);
        scl_r = 1'b1;
        wait_n(H / 2);
        r = sda_w;
        wait_n(H / 2);
        scl_r = 1'b0;
    endtask

    task automatic bus_start();
        m_low = 1'b1;
        wait_n(H);
        scl_r = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_n(2);
        m_low = 1'b0;
        wait_n(H - 2);
        scl_r = 1'b1;
        wait_n(H);
        m_low = 1'b1;
        wait_n(H);
        scl_r = 1'b0;
    endtask

    task automatic bus_stop();
        wait_n(2);
        m_low = 1'b1;
        wait_n(H - 2);
        scl_r = 1'b1;
        wait_n(H);
        m_low = 1'b0;
        wait_n(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(nack, r);
    endtask

    vec_t       vecs[5];
    vec_t       v;
    logic       ack;
    logic       rbit;
    logic [7:0] byte_v;
    int         rx0, tx0, d0, acks;

    initial begin
        vecs[0] = '{1'b0, 7'h55, 3, 8'hCB, 1'b0, 3, 0, 8'hCB, 4'd3, 1'b1};
        vecs[1] = '{1'b1, 7'h55, 2, 8'hCB, 1'b0, 0, 2, 8'hCB, 4'd7, 1'b0};
        vecs[2] = '{1'b0, 7'h2A, 1, 8'h5A, 1'b1, 0, 0, 8'hCB, 4'd7, 1'b0};
        vecs[3] = '{1'b0, 7'h55, 1, 8'h3C, 1'b0, 1, 0, 8'h3C, 4'd3, 1'b1};
        vecs[4] = '{1'b1, 7'h55, 1, 8'hA5, 1'b0, 0, 1, 8'h3C, 4'd7, 1'b0};

        wait_n(4);
        check("rst_state", state_reg, 4'd0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_w, 1'b1);
        reset = 1'b0;
        wait_n(4);
        check("idle_state", state_reg, 4'd0);

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            tx_data = v.data;
            rx0 = rx_cnt; tx0 = tx_cnt; d0 = drv_cnt; acks = 0;
            bus_start();
            write_byte({v.addr, v.rd}, ack);
            check($sformatf("v%0d_addr_ack", k), ack, v.exp_ack);
            for (int b = 0; b < v.nbytes; b++) begin
                if (v.rd) begin
                    read_byte(b == v.nbytes - 1, byte_v);
                    check($sformatf("v%0d_rd_byte%0d", k, b), byte_v, v.data);
                end else begin
                    write_byte(v.data, ack);
                    if (!ack) acks++;
                end
            end
            wait_n(H);
            check($sformatf("v%0d_state", k), state_reg, v.exp_state);
            check($sformatf("v%0d_busy", k), busy, v.exp_busy);
            check($sformatf("v%0d_data_acks", k), acks, v.rd ? 0 : v.exp_rx);
            check($sformatf("v%0d_rx_pulses", k), rx_cnt - rx0, v.exp_rx);
            check($sformatf("v%0d_tx_pulses", k), tx_cnt - tx0, v.exp_tx);
            check($sformatf("v%0d_rx_data", k), rx_data, v.exp_rx_data);
            check($sformatf("v%0d_sda_driven", k), drv_cnt != d0, !v.exp_ack);
            bus_stop();
            wait_n(4);
            check($sformatf("v%0d_stop_state", k), state_reg, 4'd0);
            check($sformatf("v%0d_stop_busy", k), busy, 1'b0);
        end

        // STOP after four data bits of a write
        rx0 = rx_cnt;
        bus_start();
        write_byte({7'h55, 1'b0}, ack);
        check("part_addr_ack", ack, 1'b0);
        clock_bit(1'b1, rbit); clock_bit(1'b0, rbit);
        clock_bit(1'b1, rbit); clock_bit(1'b0, rbit);
        bus_stop();
        wait_n(4);
        check("part_state", state_reg, 4'd0);
        check("part_rx_pulses", rx_cnt - rx0, 0);
        check("part_rx_data", rx_data, 8'h3C);

        // Repeated START after a write byte, then a read
        bus_start();
        write_byte({7'h55, 1'b0}, ack);
        write_byte(8'h11, ack);
        check("rs_wr_ack", ack, 1'b0);
        check("rs_rx_data", rx_data, 8'h11);
        bus_rstart();
        check("rs_state_addr", state_reg, 4'd1);
        tx_data = 8'h96;
        tx0 = tx_cnt;
        write_byte({7'h55, 1'b1}, ack);
        check("rs_addr_ack", ack, 1'b0);
        read_byte(1'b1, byte_v);
        check("rs_rd_byte", byte_v, 8'h96);
        check("rs_tx_pulses", tx_cnt - tx0, 1);
        wait_n(H);
        check("rs_state_wait", state_reg, 4'd7);
        bus_stop();
        wait_n(4);
        check("rs_stop_state", state_reg, 4'd0);

        // Reset while the target drives a 0 data bit
        tx_data = 8'h00;
        bus_start();
        write_byte({7'h55, 1'b1}, ack);
        check("mr_addr_ack", ack, 1'b0);
        wait_n(5);
        check("mr_state_read", state_reg, 4'd5);
        check("mr_sda_low", sda_w, 1'b0);
        check("mr_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_sda_rel", sda_w, 1'b1);
        check("mr_state", state_reg, 4'd0);
        check("mr_busy_rst", busy, 1'b0);
        check("mr_rx_data", rx_data, 8'h00);
        check("mr_rx_valid", rx_valid, 1'b0);
        check("mr_tx_req", tx_req, 1'b0);
        wait_n(2);
        reset = 1'b0;
        scl_r = 1'b1;
        m_low = 1'b0;
        wait_n(H);
        check("mr_after_state", state_reg, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: OWN_ADDR, 7'b1010101, 7-bit bus address this target answers to.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (minimum 2).
REQ-003 clk  input  1  system clock; single clock domain, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 SCL  input  1  bus clock from the upstream I2C_controller (asynchronous to clk).
REQ-006 SDA  inout  1  bus data; target drives only 1'b0 or 1'bz, never 1'b1.
REQ-007 rx_data  output  8  last byte received in a write transfer.
REQ-008 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-009 tx_data  input  8  byte to return in a read transfer; sampled when tx_req pulses.
REQ-010 tx_req  output  1  one-clk pulse when tx_data is loaded into the shift register.
REQ-011 busy  output  1  high from an addressed START until STOP or NACK exit.
REQ-012 state_reg  output  4  current FSM state encoding, for debug/bench observation.

Function
REQ-013 SCL and SDA shall pass through SYNC_STAGES flops plus one edge-detect flop; all bus events are seen SYNC_STAGES+1 clks after the pin change.
REQ-014 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-015 Data bits shall be sampled on synced SCL rising edge, MSB first; the target shall change its SDA drive only on synced SCL falling edge.
REQ-016 States: IDLE(0), ADDR(1), ADDR_ACK(2), WRITE(3), WRITE_ACK(4), READ(5), READ_ACK(6), WAIT_STOP(7).
REQ-017 IDLE -> ADDR on START; ADDR shifts 8 bits (7 address + R/W).
REQ-018 ADDR -> ADDR_ACK if address equals OWN_ADDR, drive SDA=0 for the ack bit; else -> WAIT_STOP with SDA released.
REQ-019 ADDR_ACK -> WRITE if R/W=0; -> READ if R/W=1, pulsing tx_req and loading tx_data on the SCL falling edge ending the ack bit.
REQ-020 WRITE shifts 8 bits; after the 8th rising edge rx_data updates and rx_valid pulses once; -> WRITE_ACK driving SDA=0 for one SCL period; then -> WRITE.
REQ-021 READ drives SDA=0 for 0-bits and z for 1-bits over 8 SCL periods; then releases SDA -> READ_ACK.
REQ-022 READ_ACK samples master ack: SDA=0 -> READ with next tx_data loaded and tx_req pulsed; SDA=1 (NACK) -> WAIT_STOP.
REQ-023 STOP in any state -> IDLE, SDA released, busy low, no further rx_valid/tx_req.
REQ-024 START (repeated) in any non-IDLE state -> ADDR with bit counter cleared; partial byte discarded, no rx_valid.
REQ-025 Unlimited byte count per transfer; bit counter wraps 7..0 per byte.
REQ-026 Correct operation requires each SCL high and low phase to last at least SYNC_STAGES+3 clks.

Reset
REQ-027 On reset: state_reg=IDLE, SDA=z, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, counters and shift registers zero, synchronizer flops set to 1.
REQ-028 Reset asserted mid-transfer shall release SDA on the clk edge following assertion and ignore bus activity until the next START after deassertion.

Structure
REQ-029 State encodings and START/STOP detect widths shall live in shared package i2c_pkg, also used by I2C_controller.
REQ-030 Input synchronizer plus edge/START/STOP detection shall be sub-module i2c_bus_sync, instantiated once.

Verification
REQ-031 Write addr 0x55, NUM_BYTES=3, data 0xCB -> ack low in address slot, three rx_valid pulses each rx_data=0xCB, busy low after STOP.
REQ-032 Read addr 0x55, tx_data=0xCB, 2 bytes -> SDA bits 1,1,0,0,1,0,1,1 per byte, tx_req pulses twice, master NACK -> WAIT_STOP then IDLE.
REQ-033 Write to addr 0x2A -> SDA never driven, no rx_valid, state_reg WAIT_STOP until STOP.
REQ-034 STOP after 4 data bits of a write -> state_reg IDLE, no rx_valid, rx_data unchanged.
REQ-035 Repeated START after a write byte, then read addr 0x55 -> ADDR re-entered, read proceeds with tx_req pulse.
REQ-036 reset asserted during READ with SDA driven low -> SDA z next clk, all outputs at reset values.
